// File: rtl/locked_ring_fsm.sv
// Key-locked ring controller: N-position ring whose K odd "guarded" positions
// divert into look-alike duplicate states unless the matching key bit is correct.
module locked_ring_fsm #(
    parameter int             N           = 16,
    parameter int             K           = 4,
    parameter logic [K-1:0]   CORRECT_KEY = 4'b1010,
    parameter int             CNT_W       = 8,
    localparam int            CW          = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_si,
    input  logic              key_shift,
    input  logic              key_load,
    input  logic              go,
    input  logic              dir,
    output logic [CW-1:0]     code,
    output logic              lap,
    output logic [CNT_W-1:0]  moves,
    // Debug view of the full state {dup, idx}; code alone hides the dup bit.
    output logic [CW:0]       state_dbg
);

    localparam logic ST_NORM = 1'b0;
    localparam logic ST_DUP  = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] idx, idx_nxt, tgt;
    logic          dup, dup_nxt;
    logic          lap_nxt;
    logic          guard_hit, key_ok;
    logic [K-1:0]  key_sr, key_act;

    // Target position for a move. A guarded index is at most N-3, so the
    // duplicate's forward skip (+2) can never wrap.
    always_comb begin
        tgt = idx;
        if (dup == ST_DUP) begin
            tgt = dir ? idx + CW'(2) : idx - CW'(1);
        end else if (dir) begin
            tgt = (idx == LAST) ? '0 : idx + CW'(1);
        end else begin
            tgt = (idx == '0) ? LAST : idx - CW'(1);
        end
    end

    always_comb begin
        guard_hit = 1'b0;
        key_ok    = 1'b1;
        for (int i = 0; i < K; i++) begin
            if (tgt == CW'(2 * i + 1)) begin
                guard_hit = 1'b1;
                key_ok    = (key_act[i] == CORRECT_KEY[i]);
            end
        end
    end

    always_comb begin
        idx_nxt = idx;
        dup_nxt = dup;
        lap_nxt = 1'b0;
        if (go) begin
            idx_nxt = tgt;
            dup_nxt = (guard_hit && !key_ok) ? ST_DUP : ST_NORM;
            lap_nxt = dir && (dup == ST_NORM) && (idx == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            dup   <= ST_NORM;
            lap   <= 1'b0;
            moves <= '0;
        end else begin
            idx <= idx_nxt;
            dup <= dup_nxt;
            lap <= lap_nxt;
            if (go && (moves != '1)) begin
                moves <= moves + CNT_W'(1);
            end
        end
    end

    // Key is shifted in LSB first; a load copies the pre-shift register value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sr  <= '0;
            key_act <= '0;
        end else begin
            if (key_shift) begin
                key_sr <= (key_sr >> 1) | (K'(key_si) << (K - 1));
            end
            if (key_load) begin
                key_act <= key_sr;
            end
        end
    end

    assign code      = idx;
    assign state_dbg = {dup, idx};

endmodule

// File: tb/tb_locked_ring_fsm.sv
// Bench for locked_ring_fsm: constant vector table, hand-written corner cases
// and random traffic checked against a position-arithmetic reference model.
module tb_locked_ring_fsm;

    localparam int N = 16;
    localparam int K = 4;
    localparam int CNT_W = 4;
    localparam logic [K-1:0] CK = 4'b1010;
    localparam int W = 4 + 1 + 1 + CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_si = 1'b0, key_shift = 1'b0, key_load = 1'b0, go = 1'b0, dir = 1'b0;
    logic [3:0] code;
    logic lap;
    logic [CNT_W-1:0] moves;
    logic [4:0] state_dbg;

    int n_checks = 0;
    int n_fail = 0;

    locked_ring_fsm #(.N(N), .K(K), .CORRECT_KEY(CK), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .key_si(key_si), .key_shift(key_shift),
        .key_load(key_load), .go(go), .dir(dir), .code(code), .lap(lap),
        .moves(moves), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_pos, m_moves;
    bit m_dup, m_lap;
    int m_sr[K];
    int m_act[K];
    logic [W-1:0] exp_q[$];

    function automatic int guard_of(int p);
        return (p % 2 == 1 && p < 2 * K) ? p / 2 : -1;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_moves = 0; m_dup = 0; m_lap = 0;
        for (int i = 0; i < K; i++) begin
            m_sr[i] = 0;
            m_act[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input bit g, input bit d, input bit sh, input bit si, input bit ld);
        int old_act[K];
        int t, gi;
        logic [K-1:0] ck;
        logic [W-1:0] e;
        ck = CK;
        old_act = m_act;
        if (ld) m_act = m_sr;
        if (sh) begin
            for (int i = 0; i < K - 1; i++) m_sr[i] = m_sr[i + 1];
            m_sr[K - 1] = int'(si);
        end
        m_lap = 0;
        if (g) begin
            if (m_dup) t = d ? m_pos + 2 : m_pos - 1;
            else t = (m_pos + (d ? 1 : N - 1)) % N;
            m_lap = d && !m_dup && (m_pos == N - 1);
            gi = guard_of(t);
            m_dup = (gi >= 0) && (old_act[gi] != int'(ck[gi]));
            m_pos = t;
            m_moves = (m_moves < (1 << CNT_W) - 1) ? m_moves + 1 : m_moves;
        end
        e = {4'(m_pos), m_dup, m_lap, CNT_W'(m_moves)};
        exp_q.push_back(e);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check("model_queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("model", 32'({code, state_dbg[4], lap, moves}), 32'(e));
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; drives one cycle and checks after the next rising edge.
    task automatic step(input bit g, input bit d, input bit sh, input bit si, input bit ld);
        go = g; dir = d; key_shift = sh; key_si = si; key_load = ld;
        @(posedge clk);
        model_step(g, d, sh, si, ld);
        @(negedge clk);
        go = 1'b0; key_shift = 1'b0; key_load = 1'b0; key_si = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_code", 32'(code), 32'd0);
        check("rst_lap", 32'(lap), 32'd0);
        check("rst_moves", 32'(moves), 32'd0);
        check("rst_dup", 32'(state_dbg[4]), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_correct_key();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic go, dir, shift, si, load;
        logic [3:0] code;
        logic dup, lap;
        logic [3:0] moves;
    } vec_t;

    function automatic vec_t mk(logic g, logic d, logic sh, logic si, logic ld,
                                logic [3:0] c, logic du, logic lp, logic [3:0] mv);
        vec_t v;
        v.go = g; v.dir = d; v.shift = sh; v.si = si; v.load = ld;
        v.code = c; v.dup = du; v.lap = lp; v.moves = mv;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        vec_t tbl[$];
        int exp5_code[6] = '{1, 2, 3, 5, 7, 9};
        int exp5_dup[6] = '{0, 0, 1, 1, 1, 0};

        @(negedge clk);
        do_reset();

        // Reset key 0000, then load the correct key while parked.
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd1, 0, 0, 4'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd2, 0, 0, 4'd2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd3, 1, 0, 4'd3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd5, 0, 0, 4'd4));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd6, 0, 0, 4'd5));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd7, 1, 0, 4'd6));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd6, 0, 0, 4'd7));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd6, 0, 0, 4'd7));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'd6, 0, 0, 4'd7));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'd6, 0, 0, 4'd7));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'd6, 0, 0, 4'd7));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4'd6, 0, 0, 4'd7));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd7, 0, 0, 4'd8));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd8, 0, 0, 4'd9));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].go, tbl[i].dir, tbl[i].shift, tbl[i].si, tbl[i].load);
            check($sformatf("tbl_row%0d", i),
                  32'({code, state_dbg[4], lap, moves}),
                  32'({tbl[i].code, tbl[i].dup, tbl[i].lap, tbl[i].moves}));
        end

        // Correct key, full forward loop with lap and saturation.
        do_reset();
        load_correct_key();
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 0, 0);
            check($sformatf("loop_code%0d", i), 32'(code), 32'((i + 1) % 16));
            check($sformatf("loop_lap%0d", i), 32'(lap), (i == 15) ? 32'd1 : 32'd0);
            check($sformatf("loop_moves%0d", i), 32'(moves), 32'((i + 1 < 15) ? i + 1 : 15));
        end

        // Correct key, backward from 0: no lap on backward wrap.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            check($sformatf("back_code%0d", i), 32'(code), 32'(15 - i));
            check($sformatf("back_lap%0d", i), 32'(lap), 32'd0);
        end

        // Wrong key to d_1, step back, then re-enter with the correct key.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        check("d1_reached", 32'(state_dbg), 32'h13);
        step(1, 0, 0, 0, 0);
        check("d1_back", 32'(state_dbg), 32'h02);
        load_correct_key();
        step(1, 1, 0, 0, 0);
        check("reentry_g1", 32'(state_dbg), 32'h03);
        step(1, 1, 0, 0, 0);
        check("reentry_noskip", 32'(state_dbg), 32'h04);

        // Load during the fourth shift captures the three-shift contents.
        do_reset();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, 0);
            check($sformatf("sl_code%0d", i), 32'(code), 32'(exp5_code[i]));
            check($sformatf("sl_dup%0d", i), 32'(state_dbg[4]), 32'(exp5_dup[i]));
        end
        // Asynchronous reset in the middle of a low phase at code 9.
        do_reset();

        // Saturation over 20 gos with the reset key.
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
        check("sat_moves", 32'(moves), 32'd15);
        check("sat_state", 32'(state_dbg), 32'h17);

        // go and key_load at the same edge: guard still uses the old key.
        do_reset();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        check("same_edge_old_key", 32'(state_dbg), 32'h13);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
